// File: rtl/ifetch_queue.sv
// Fetch PC owner and small decode-side queue: issues one fetch address at a time to
// the align buffer, classifies the returned parcel as 16/32-bit and queues it for decode.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            flush_pc_i,
  output logic                       buff_req_valid_o,
  output logic [XLEN-1:0]            buff_req_addr_o,
  input  logic                       buff_res_valid_i,
  input  logic [31:0]                buff_res_blk_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [XLEN-1:0]            deq_pc_o,
  output logic [31:0]                deq_instr_o,
  output logic                       deq_compressed_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            compressed;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_ent, head, hold_q, out_ent;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] fetch_pc;
  logic            full, push, pop, comp;

  assign full             = (count_q == CW'(DEPTH));
  assign buff_req_valid_o = rst_ni & ~flush_i & ~full;
  assign buff_req_addr_o  = fetch_pc;
  assign push             = buff_req_valid_o & buff_res_valid_i;
  assign pop              = ~flush_i & (count_q != '0) & deq_ready_i;

  assign comp   = (buff_res_blk_i[1:0] != 2'b11);
  assign wr_ent = '{pc:         fetch_pc,
                    instr:      comp ? {16'h0, buff_res_blk_i[15:0]} : buff_res_blk_i,
                    compressed: comp};

  assign head        = mem[rd_ptr];
  assign deq_valid_o = (count_q != '0);
  // When empty, the outputs keep showing the last head seen rather than stale storage.
  assign out_ent          = deq_valid_o ? head : hold_q;
  assign deq_pc_o         = out_ent.pc;
  assign deq_instr_o      = out_ent.instr;
  assign deq_compressed_o = out_ent.compressed;
  assign count_o          = count_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else if (flush_i) begin
      fetch_pc <= {flush_pc_i[XLEN-1:1], 1'b0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (deq_valid_o) hold_q <= head;
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + (comp ? XLEN'(2) : XLEN'(4));
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, mixed widths, miss stall, full/wrap,
// flush, async reset and PC wraparound.
module tb_ifetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        buff_req_valid_o;
  logic [31:0] buff_req_addr_o;
  logic        buff_res_valid_i;
  logic [31:0] buff_res_blk_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_instr_o;
  logic        deq_compressed_o;
  logic [2:0]  count_o;

  int tests = 0;
  int fails = 0;

  ifetch_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .buff_req_valid_o(buff_req_valid_o), .buff_req_addr_o(buff_req_addr_o),
    .buff_res_valid_i(buff_res_valid_i), .buff_res_blk_i(buff_res_blk_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_pc_o(deq_pc_o),
    .deq_instr_o(deq_instr_o), .deq_compressed_o(deq_compressed_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    buff_res_valid_i = 1'b0; buff_res_blk_i = '0; deq_ready_i = 1'b0;
    #2;
    chk("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("rst_req_valid", 32'(buff_req_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_deq_pc", deq_pc_o, 32'd0);
    chk("rst_deq_instr", deq_instr_o, 32'd0);
    #10 rst_ni = 1'b1;

    // streaming 32-bit ops, decode always ready
    buff_res_valid_i = 1'b1; buff_res_blk_i = 32'h0000_0013; deq_ready_i = 1'b1;
    #1;
    chk("s_req_valid", 32'(buff_req_valid_o), 32'd1);
    chk("s_req_addr0", buff_req_addr_o, 32'h8000_0000);
    chk("s_no_bypass", 32'(deq_valid_o), 32'd0);
    tick();
    chk("s_pc0", deq_pc_o, 32'h8000_0000);
    chk("s_instr0", deq_instr_o, 32'h0000_0013);
    chk("s_comp0", 32'(deq_compressed_o), 32'd0);
    chk("s_addr1", buff_req_addr_o, 32'h8000_0004);
    tick();
    chk("s_pc1", deq_pc_o, 32'h8000_0004);
    chk("s_cnt1", 32'(count_o), 32'd1);
    tick();
    chk("s_pc2", deq_pc_o, 32'h8000_0008);
    buff_res_valid_i = 1'b0;
    tick();
    chk("s_empty", 32'(deq_valid_o), 32'd0);
    chk("s_hold_pc", deq_pc_o, 32'h8000_0008);
    chk("s_cnt0", 32'(count_o), 32'd0);

    // mixed compressed / full stream
    flush_i = 1'b1; flush_pc_i = 32'h8000_0000; deq_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("m_addr0", buff_req_addr_o, 32'h8000_0000);
    buff_res_valid_i = 1'b1; buff_res_blk_i = 32'hABCD_4501;
    tick();
    chk("m_pc0", deq_pc_o, 32'h8000_0000);
    chk("m_instr0", deq_instr_o, 32'h0000_4501);
    chk("m_comp0", 32'(deq_compressed_o), 32'd1);
    chk("m_addr1", buff_req_addr_o, 32'h8000_0002);
    buff_res_blk_i = 32'h0000_0013;
    tick();
    chk("m_addr2", buff_req_addr_o, 32'h8000_0006);
    chk("m_cnt2", 32'(count_o), 32'd2);
    chk("m_head_held", deq_pc_o, 32'h8000_0000);
    buff_res_valid_i = 1'b0; deq_ready_i = 1'b1;
    tick();
    chk("m_pc1", deq_pc_o, 32'h8000_0002);
    chk("m_instr1", deq_instr_o, 32'h0000_0013);
    chk("m_comp1", 32'(deq_compressed_o), 32'd0);
    tick();
    chk("m_cnt0", 32'(count_o), 32'd0);

    // align buffer miss: request held for 5 cycles
    deq_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("miss_valid", 32'(buff_req_valid_o), 32'd1);
      chk("miss_addr", buff_req_addr_o, 32'h8000_0006);
      chk("miss_cnt", 32'(count_o), 32'd0);
      tick();
    end
    buff_res_valid_i = 1'b1; buff_res_blk_i = 32'h0000_0013;
    tick();
    buff_res_valid_i = 1'b0;
    chk("miss_push_cnt", 32'(count_o), 32'd1);
    chk("miss_push_pc", deq_pc_o, 32'h8000_0006);
    tick();
    chk("miss_one_push", 32'(count_o), 32'd1);
    chk("miss_next_addr", buff_req_addr_o, 32'h8000_000A);

    // fill to full, pop one, refill across pointer wrap, drain in order
    flush_i = 1'b1; flush_pc_i = 32'h8000_0000;
    tick();
    flush_i = 1'b0; buff_res_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      buff_res_blk_i = 32'h0000_0003 | (32'(i) << 8);
      tick();
    end
    chk("f_cnt4", 32'(count_o), 32'd4);
    chk("f_req_drop", 32'(buff_req_valid_o), 32'd0);
    buff_res_blk_i = 32'h0000_0403;
    tick();
    chk("f_stay4", 32'(count_o), 32'd4);
    deq_ready_i = 1'b1;
    tick();
    chk("f_cnt3", 32'(count_o), 32'd3);
    chk("f_req_back", 32'(buff_req_valid_o), 32'd1);
    chk("f_head_pc", deq_pc_o, 32'h8000_0004);
    deq_ready_i = 1'b0;
    tick();
    chk("f_refill", 32'(count_o), 32'd4);
    buff_res_valid_i = 1'b0; deq_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("f_order_pc", deq_pc_o, 32'h8000_0000 + 32'(4 * i));
      chk("f_order_instr", deq_instr_o, 32'h0000_0003 | (32'(i) << 8));
      tick();
    end
    chk("f_drained", 32'(count_o), 32'd0);

    // flush at count=3 with a response in the flush cycle
    deq_ready_i = 1'b0; buff_res_valid_i = 1'b1; buff_res_blk_i = 32'h0000_0013;
    tick(); tick(); tick();
    chk("fl_cnt3", 32'(count_o), 32'd3);
    flush_i = 1'b1; flush_pc_i = 32'h8000_0103; deq_ready_i = 1'b1;
    #1;
    chk("fl_req_low", 32'(buff_req_valid_o), 32'd0);
    tick();
    flush_i = 1'b0; buff_res_valid_i = 1'b0; deq_ready_i = 1'b0;
    chk("fl_cnt0", 32'(count_o), 32'd0);
    chk("fl_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("fl_addr", buff_req_addr_o, 32'h8000_0102);
    tick();
    chk("fl_no_enq", 32'(count_o), 32'd0);

    // async reset between edges
    buff_res_valid_i = 1'b1; buff_res_blk_i = 32'h0000_0013;
    tick(); tick();
    chk("ar_cnt2", 32'(count_o), 32'd2);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("ar_req_valid", 32'(buff_req_valid_o), 32'd0);
    chk("ar_cnt", 32'(count_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("ar_restart", buff_req_addr_o, 32'h8000_0000);
    tick();
    chk("ar_pc", deq_pc_o, 32'h8000_0000);
    chk("ar_cnt1", 32'(count_o), 32'd1);

    // PC wraps at 2^XLEN
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFE;
    tick();
    flush_i = 1'b0; buff_res_blk_i = 32'h0000_0001;
    tick();
    buff_res_valid_i = 1'b0;
    chk("w_addr", buff_req_addr_o, 32'h0000_0000);
    chk("w_pc", deq_pc_o, 32'hFFFF_FFFE);
    chk("w_instr", deq_instr_o, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
